// File: rtl/montre_timer_sequencer.sv
// Purpose: Avalon-MM master that programs the interval timer, services its IRQ and keeps BCD hh:mm:ss.
// Latency: bus outputs are registered from the next state; time and sec_tick update on the edge ending a confirmed status read.
// Backpressure: none; the slave has no waitrequest, so every transfer is one cycle. A stop outside RUN is held pending until RUN.
module montre_timer_sequencer #(
    parameter logic [31:0] PERIOD = 32'd49_999_999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        set_en,
    input  logic [7:0]  set_hour,
    input  logic [7:0]  set_min,
    input  logic [7:0]  set_sec,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        timer_irq,
    output logic [7:0]  hour,
    output logic [7:0]  min,
    output logic [7:0]  sec,
    output logic        sec_tick,
    output logic        running
);

    // Timer slave register map and control words.
    localparam logic [2:0]  REG_STATUS   = 3'd0;
    localparam logic [2:0]  REG_CONTROL  = 3'd1;
    localparam logic [2:0]  REG_PERIODL  = 3'd2;
    localparam logic [2:0]  REG_PERIODH  = 3'd3;
    localparam logic [15:0] CTRL_RUN     = 16'h0007;  // ITO | CONT | START
    localparam logic [15:0] CTRL_STOP    = 16'h0008;  // STOP, interrupts off

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        RD_ST,
        RD_WAIT,
        CLR_ST,
        STOP_WR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        stop_pend;
    logic        stop_pend_nxt;

    logic        cs_nxt;
    logic        write_n_nxt;
    logic [2:0]  addr_nxt;
    logic [15:0] wdata_nxt;
    logic        run_nxt;

    // Timeout confirmed: TO bit of the status word returned for our read.
    logic        to_ok;
    assign to_ok = (state == RD_WAIT) && av_readdata[0];

    // Only the TO bit of the status register matters here.
    logic        unused_rd_bits;
    assign unused_rd_bits = ^av_readdata[15:1];

    // Seconds/minutes digit pair: ones wrap at 9 (or any illegal value), tens wrap at 5; bit 8 is the carry out.
    function automatic logic [8:0] inc_base60(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        logic       c;
        lo = v[3:0];
        hi = v[7:4];
        c  = 1'b0;
        if (lo >= 4'd9) begin
            lo = 4'd0;
            if (hi >= 4'd5) begin
                hi = 4'd0;
                c  = 1'b1;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {c, hi, lo};
    endfunction

    // Hours digit pair: 23 wraps to 00, ones wrap at 9 (or any illegal value) into the tens digit.
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (hi >= 4'd2 && lo >= 4'd3) begin
            lo = 4'd0;
            hi = 4'd0;
        end else if (lo >= 4'd9) begin
            lo = 4'd0;
            hi = (hi >= 4'd2) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // Next state, pending-stop bookkeeping and the bus cycle the next state will drive.
    always_comb begin
        state_nxt     = state;
        stop_pend_nxt = stop_pend;
        cs_nxt        = 1'b0;
        write_n_nxt   = 1'b1;
        addr_nxt      = 3'd0;
        wdata_nxt     = 16'h0000;
        run_nxt       = 1'b0;

        case (state)
            IDLE:    if (start) state_nxt = WR_PL;
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_CTRL;
            WR_CTRL: state_nxt = RUN;
            RUN: begin
                if (stop_pend || stop) state_nxt = STOP_WR;
                else if (timer_irq)    state_nxt = RD_ST;
            end
            RD_ST:   state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = av_readdata[0] ? CLR_ST : RUN;
            CLR_ST:  state_nxt = RUN;
            STOP_WR: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // RUN acts on stop directly; elsewhere (except IDLE) it waits for the next RUN entry.
        if (state == STOP_WR)
            stop_pend_nxt = 1'b0;
        else if (stop && state != IDLE && state != RUN)
            stop_pend_nxt = 1'b1;

        case (state_nxt)
            WR_PL: begin
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                addr_nxt    = REG_PERIODL;
                wdata_nxt   = PERIOD[15:0];
            end
            WR_PH: begin
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                addr_nxt    = REG_PERIODH;
                wdata_nxt   = PERIOD[31:16];
            end
            // Control goes last: a period write halts the slave counter.
            WR_CTRL: begin
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                addr_nxt    = REG_CONTROL;
                wdata_nxt   = CTRL_RUN;
            end
            RD_ST: begin
                cs_nxt      = 1'b1;
                addr_nxt    = REG_STATUS;
            end
            CLR_ST: begin
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                addr_nxt    = REG_STATUS;
            end
            STOP_WR: begin
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                addr_nxt    = REG_CONTROL;
                wdata_nxt   = CTRL_STOP;
            end
            default: ;
        endcase

        run_nxt = (state_nxt == RUN) || (state_nxt == RD_ST) ||
                  (state_nxt == RD_WAIT) || (state_nxt == CLR_ST);
    end

    // State register and pending stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    // Registered bus outputs and running flag, so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_address    <= 3'd0;
            av_writedata  <= 16'h0000;
            running       <= 1'b0;
        end else begin
            av_chipselect <= cs_nxt;
            av_write_n    <= write_n_nxt;
            av_address    <= addr_nxt;
            av_writedata  <= wdata_nxt;
            running       <= run_nxt;
        end
    end

    logic [8:0] sec_inc;
    logic [8:0] min_inc;
    logic [7:0] hour_inc;

    // Cascaded BCD increment of the current time.
    always_comb begin
        sec_inc  = inc_base60(sec);
        min_inc  = {1'b0, min};
        hour_inc = hour;
        if (sec_inc[8]) min_inc = inc_base60(min);
        if (min_inc[8]) hour_inc = inc_hour(hour);
    end

    // Time-of-day: a set load wins over a same-cycle timeout, which is then lost but still ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hour     <= 8'h00;
            min      <= 8'h00;
            sec      <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= to_ok;
            if (set_en) begin
                hour <= set_hour;
                min  <= set_min;
                sec  <= set_sec;
            end else if (to_ok) begin
                hour <= hour_inc;
                min  <= min_inc[7:0];
                sec  <= sec_inc[7:0];
            end
        end
    end

endmodule

// File: tb/tb_montre_timer_sequencer.sv
// Bench for montre_timer_sequencer: directed and randomized timeouts against a seconds-of-day model.
// Inputs are driven and outputs sampled 1 time unit after the falling clock edge.
// A small status-register slave model answers reads one cycle after the address phase.
module tb_montre_timer_sequencer;

    localparam logic [31:0] TB_PERIOD = 32'd9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        set_en;
    logic [7:0]  set_hour;
    logic [7:0]  set_min;
    logic [7:0]  set_sec;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        timer_irq;
    logic [7:0]  hour;
    logic [7:0]  min;
    logic [7:0]  sec;
    logic        sec_tick;
    logic        running;

    logic [15:0] status_val;
    int          tests  = 0;
    int          errors = 0;
    int          model_t = 0;   // seconds since midnight

    always #5 clk = ~clk;

    montre_timer_sequencer #(.PERIOD(TB_PERIOD)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .set_en        (set_en),
        .set_hour      (set_hour),
        .set_min       (set_min),
        .set_sec       (set_sec),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .timer_irq     (timer_irq),
        .hour          (hour),
        .min           (min),
        .sec           (sec),
        .sec_tick      (sec_tick),
        .running       (running)
    );

    // Slave status register: read data registered, valid only the cycle after a read of address 0.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            av_readdata <= 16'h0000;
        else if (av_chipselect && av_write_n && av_address == 3'd0)
            av_readdata <= status_val;
        else
            av_readdata <= 16'h0000;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] i2b(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int hms(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return b2i(h) * 3600 + b2i(m) * 60 + b2i(s);
    endfunction

    task automatic chk_time(input string tag);
        logic [23:0] exp;
        exp = {i2b(model_t / 3600), i2b((model_t / 60) % 60), i2b(model_t % 60)};
        chk(tag, 32'({hour, min, sec}), 32'(exp));
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] a, input logic [15:0] d);
        chk(tag, 32'({av_chipselect, av_write_n, av_address, av_writedata}), 32'({1'b1, 1'b0, a, d}));
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({av_chipselect, av_write_n}), 32'h1);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_en = 1'b1; set_hour = h; set_min = m; set_sec = s;
        cyc();
        set_en = 1'b0;
        chk("set_load", 32'({hour, min, sec}), 32'({h, m, s}));
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_bus("wr_period_lo", 3'd2, TB_PERIOD[15:0]);
        cyc();
        chk_bus("wr_period_hi", 3'd3, TB_PERIOD[31:16]);
        cyc();
        chk_bus("wr_ctrl", 3'd1, 16'h0007);
        chk("running_in_ctrl", 32'(running), 0);
        cyc();
        chk_quiet("quiet_after_ctrl");
        chk("running_after_ctrl", 32'(running), 1);
    endtask

    // One irq episode from RUN. confirm selects TO=1/0, collide drives set_en in the RD_WAIT cycle,
    // stop_w pulses stop in RD_WAIT (used with confirm only).
    task automatic timeout(input bit confirm, input bit collide, input logic [7:0] ch,
                           input logic [7:0] cm, input logic [7:0] cs, input bit stop_w);
        bit found;
        found      = 1'b0;
        status_val = confirm ? 16'h0003 : 16'h0002;
        timer_irq  = 1'b1;
        for (int n = 0; n < 8 && !found; n++) begin
            cyc();
            if (av_chipselect === 1'b1 && av_write_n === 1'b1 && av_address === 3'd0) found = 1'b1;
        end
        chk("status_read_seen", 32'(found), 1);
        if (!found) begin
            timer_irq = 1'b0;
            return;
        end
        cyc();
        chk("rd_wait_quiet", 32'({av_chipselect, sec_tick}), 0);
        if (collide) begin
            set_en = 1'b1; set_hour = ch; set_min = cm; set_sec = cs;
        end
        if (stop_w) stop = 1'b1;
        cyc();
        set_en    = 1'b0;
        stop      = 1'b0;
        timer_irq = 1'b0;
        if (confirm) begin
            chk_bus("clear_status_wr", 3'd0, 16'h0000);
            chk("tick_high", 32'(sec_tick), 1);
            model_t = collide ? hms(ch, cm, cs) : (model_t + 1) % 86400;
        end else begin
            chk("spurious_quiet", 32'({av_chipselect, sec_tick}), 0);
            chk("spurious_running", 32'(running), 1);
            if (collide) model_t = hms(ch, cm, cs);
        end
        cyc();
        chk("tick_one_cycle", 32'(sec_tick), 0);
        chk_time("time_after_timeout");
        chk_quiet("quiet_in_run");
        if (stop_w) begin
            cyc();
            chk_bus("stop_wr", 3'd1, 16'h0008);
            cyc();
            chk_quiet("quiet_in_idle");
            chk("running_idle", 32'(running), 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; set_en = 1'b0;
        set_hour = 8'h00; set_min = 8'h00; set_sec = 8'h00;
        timer_irq = 1'b0; status_val = 16'h0000;
        cyc();
        cyc();
        chk("rst_bus", 32'({av_chipselect, av_write_n, av_address, av_writedata}), 32'({1'b0, 1'b1, 3'd0, 16'h0}));
        chk("rst_time", 32'({hour, min, sec}), 0);
        chk("rst_flags", 32'({sec_tick, running}), 0);
        reset_n = 1'b1;
        cyc();
        cyc();

        // stop in IDLE must leave nothing pending
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_quiet("idle_stop_ignored");
        end
        do_start();
        cyc();
        chk_quiet("no_stale_stop");

        // first confirmed timeout
        timeout(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("sec_00_to_01", 32'(sec), 32'h01);
        // spurious irq
        timeout(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("spurious_sec_kept", 32'(sec), 32'h01);

        // rollovers
        set_time(8'h23, 8'h59, 8'h59); model_t = hms(8'h23, 8'h59, 8'h59);
        timeout(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("day_wrap", 32'({hour, min, sec}), 32'h000000);
        set_time(8'h00, 8'h00, 8'h09); model_t = 9;
        timeout(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("sec_digit_carry", 32'({hour, min, sec}), 32'h000010);
        set_time(8'h00, 8'h09, 8'h59); model_t = 599;
        timeout(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("min_digit_carry", 32'({hour, min, sec}), 32'h001000);

        // illegal ones digit forced to 0 with a carry
        set_time(8'h00, 8'h00, 8'h0A); model_t = 9;
        timeout(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("illegal_digit", 32'(sec), 32'h10);

        // set_en collides with a confirmed timeout
        timeout(1'b1, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0);
        chk("collision_set_wins", 32'({hour, min, sec}), 32'h120000);

        // start while running produces no bus traffic
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_quiet("run_start_ignored");
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_quiet("run_start_ignored");
        end

        // randomized episodes
        for (int i = 0; i < 16; i++) begin
            logic [7:0] rh, rm, rs;
            rh = i2b(int'($urandom_range(0, 23)));
            rm = i2b(int'($urandom_range(0, 59)));
            rs = i2b(int'($urandom_range(0, 59)));
            if ($urandom_range(0, 2) == 0) begin
                set_time(rh, rm, rs);
                model_t = hms(rh, rm, rs);
                rh = i2b(int'($urandom_range(0, 23)));
                rs = 8'h59;
            end
            timeout(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rh, rm, rs, 1'b0);
        end

        // stop during RD_WAIT: clear completes, then the stop write, then IDLE
        timeout(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // reset while writing the high period half
        set_time(8'h07, 8'h30, 8'h15); model_t = hms(8'h07, 8'h30, 8'h15);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk_bus("pre_reset_wr_hi", 3'd3, TB_PERIOD[31:16]);
        reset_n = 1'b0;
        #1;
        chk("async_rst_bus", 32'({av_chipselect, av_write_n}), 32'h1);
        chk("async_rst_time", 32'({hour, min, sec, running}), 0);
        model_t = 0;
        cyc();
        reset_n = 1'b1;
        cyc();
        chk_quiet("quiet_after_reset");
        chk_time("time_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
